att_out_streamer: RTL and testbench
===================================

Name: att_out_streamer

Overview:
Downstream stage of the attention block. Captures the full DIM x D_K attention output matrix in one cycle when the attention block pulses its data-valid, then streams it row-major as fixed-width beats over a valid/ready interface to the next consumer (output projection / DDR writer). Single capture buffer; back-pressure toward the attention block is signalled with O_IN_RDY, and lost matrices are flagged.

Parameters:
D_W, 8, element width in bits
DIM, 16, matrix rows (sequence length)
D_K, 128, matrix columns; must be a multiple of BEAT
BEAT, 16, elements per output beat

Ports:
I_CLK  input  1  clock, all logic on rising edge
I_SYNC_RST  input  1  synchronous reset, active-high
I_DATA_VLD  input  1  one-cycle pulse from attention block O_DATA_VLD
I_ATT_DATA  input  [0:DIM-1][0:D_K-1] x D_W  attention output matrix, valid with I_DATA_VLD
O_IN_RDY  output  1  high when a new matrix can be captured
O_TVALID  output  1  output beat valid
I_TREADY  input  1  consumer ready
O_TDATA  output  BEAT*D_W  beat payload; element j at bits [j*D_W +: D_W]
O_TROW  output  clog2(DIM)  row index of current beat
O_ROW_LAST  output  1  current beat is last beat of its row
O_TLAST  output  1  current beat is last beat of matrix
O_DONE  output  1  one-cycle pulse after final beat accepted
O_OVF  output  1  sticky: a matrix arrived while not ready

Behaviour:
- Reset (I_SYNC_RST=1 at clock edge): state IDLE, O_IN_RDY=1, O_TVALID=0, O_TDATA=0, O_TROW=0, O_ROW_LAST=0, O_TLAST=0, O_DONE=0, O_OVF=0, row/beat counters 0. Reset mid-stream aborts the stream immediately; buffer contents become don't-care.
- States: IDLE -> STREAM on I_DATA_VLD & O_IN_RDY (matrix registered into buffer that edge). STREAM -> DONE when O_TVALID & I_TREADY & O_TLAST. DONE -> IDLE unconditionally next cycle.
- O_IN_RDY = 1 only in IDLE. O_DONE = 1 only in DONE.
- Latency: I_DATA_VLD at edge N -> O_TVALID=1 from cycle after N with beat 0 (row 0, columns 0..BEAT-1).
- Beat b of row r carries I_ATT_DATA[r][b*BEAT + j] for j=0..BEAT-1. Beats per row BPR = D_K/BEAT (default 8); total beats DIM*BPR (default 128).
- Handshake: beat advances only on O_TVALID & I_TREADY. While O_TVALID & !I_TREADY, O_TDATA, O_TROW, O_ROW_LAST, O_TLAST hold stable. O_TVALID stays high throughout STREAM (no bubbles when I_TREADY held high: one beat per cycle, 128 consecutive cycles).
- Beat counter wraps 0 at BPR-1 and increments row; O_ROW_LAST = (beat==BPR-1); O_TLAST = O_ROW_LAST & (row==DIM-1).
- O_TDATA driven from buffer via mux on (row, beat); registered or combinational from registered counters, but must be valid in same cycle as O_TVALID.
- I_DATA_VLD while O_IN_RDY=0 (STREAM or DONE): matrix ignored, current stream unaffected, O_OVF set and held until reset.
- I_DATA_VLD in the same cycle as the DONE->IDLE transition: ignored (O_IN_RDY is 0 in DONE), O_OVF set.
- I_TREADY high while O_TVALID low: no effect.

Decomposition:
- Shared package (att_pkg): D_W/DIM/D_K/BEAT defaults, derived BPR and clog2 widths, state enum {IDLE, STREAM, DONE}.
- One natural sub-module: att_beat_mux (combinational selection of BEAT elements from buffer given row/beat index). Buffer, counters and FSM stay in top.

Test Plan:
- Reset then one matrix with element [r][c] = (r*8 + c) mod 256, I_TREADY=1 -> O_TVALID rises one cycle after pulse, 128 consecutive beats, beat 0 bytes 0x00..0x0F, beat 8 (row 1, beat 0) bytes 0x08..0x17, O_ROW_LAST every 8th beat, O_TLAST on beat 127, O_DONE one cycle later, O_IN_RDY back to 1 the cycle after that.
- Same matrix with I_TREADY random ~50% -> payload sequence identical to previous case; O_TDATA/O_TLAST stable during every stall cycle; no beat duplicated or dropped.
- Second I_DATA_VLD pulse at beat 40 with different data -> stream continues with original data, O_OVF=1 and stays 1; after O_DONE, a new pulse is accepted normally.
- I_SYNC_RST asserted at beat 60 -> next cycle O_TVALID=0, O_IN_RDY=1, O_OVF=0; fresh matrix then streams from row 0 beat 0.
- I_TREADY held 0 for 20 cycles after capture -> O_TVALID=1 with beat 0 held all 20 cycles; total completion = 20 + 128 accept cycles.
- Back-to-back: second pulse exactly in the DONE cycle -> ignored, O_OVF=1; pulse one cycle later (IDLE) -> captured, streams.

Source files
------------

// File: rtl/att_pkg.sv
// Shared sizing and state encoding for the attention output streamer.
package att_pkg;

  localparam int D_W  = 8;
  localparam int DIM  = 16;
  localparam int D_K  = 128;
  localparam int BEAT = 16;

  localparam int BPR = D_K / BEAT;
  localparam int BW  = (BPR > 1) ? $clog2(BPR) : 1;
  localparam int RW  = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int CW  = (D_K > 1) ? $clog2(D_K) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/att_beat_mux.sv
// Selects the BEAT consecutive elements of one row segment from the capture buffer.
module att_beat_mux
  import att_pkg::*;
(
  input  logic [0:DIM-1][0:D_K-1][D_W-1:0] mat,
  input  logic [RW-1:0]                    row,
  input  logic [BW-1:0]                    beat,
  output logic [BEAT*D_W-1:0]              data
);

  // Element j of the beat comes from column beat*BEAT + j of the selected row.
  always_comb begin
    data = {(BEAT*D_W){1'b0}};
    for (int j = 0; j < BEAT; j++) begin
      data[j*D_W +: D_W] = mat[row][CW'(int'(beat) * BEAT + j)];
    end
  end

endmodule

// File: rtl/att_out_streamer.sv
// Captures one DIM x D_K attention matrix and streams it row-major as valid/ready beats.
module att_out_streamer
  import att_pkg::*;
(
  input  logic                             I_CLK,
  input  logic                             I_SYNC_RST,
  input  logic                             I_DATA_VLD,
  input  logic [0:DIM-1][0:D_K-1][D_W-1:0] I_ATT_DATA,
  output logic                             O_IN_RDY,
  output logic                             O_TVALID,
  input  logic                             I_TREADY,
  output logic [BEAT*D_W-1:0]              O_TDATA,
  output logic [RW-1:0]                    O_TROW,
  output logic                             O_ROW_LAST,
  output logic                             O_TLAST,
  output logic                             O_DONE,
  output logic                             O_OVF
);

  localparam logic [BW-1:0] BEAT_PENULT = BW'(BPR - 2);
  localparam logic [RW-1:0] ROW_FINAL   = RW'(DIM - 1);

  state_t                           state_r;
  logic [0:DIM-1][0:D_K-1][D_W-1:0] buf_r;
  logic [RW-1:0]                    row_r;
  logic [BW-1:0]                    beat_r;
  logic                             in_rdy_r;
  logic                             tvalid_r;
  logic                             row_last_r;
  logic                             tlast_r;
  logic                             done_r;
  logic                             ovf_r;
  logic [BEAT*D_W-1:0]              beat_data_s;

  // Capture buffer: loaded only when a matrix is accepted; contents are don't-care otherwise.
  always_ff @(posedge I_CLK) begin
    if (state_r == IDLE && I_DATA_VLD) begin
      buf_r <= I_ATT_DATA;
    end
  end

  // Control FSM with counters and registered stream flags.
  always_ff @(posedge I_CLK) begin
    if (I_SYNC_RST) begin
      state_r    <= IDLE;
      row_r      <= {RW{1'b0}};
      beat_r     <= {BW{1'b0}};
      in_rdy_r   <= 1'b1;
      tvalid_r   <= 1'b0;
      row_last_r <= 1'b0;
      tlast_r    <= 1'b0;
      done_r     <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      // A matrix offered while busy is lost; remember that until reset.
      if (I_DATA_VLD && !in_rdy_r) begin
        ovf_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (I_DATA_VLD) begin
            state_r    <= STREAM;
            in_rdy_r   <= 1'b0;
            tvalid_r   <= 1'b1;
            row_r      <= {RW{1'b0}};
            beat_r     <= {BW{1'b0}};
            row_last_r <= 1'b0;
            tlast_r    <= 1'b0;
          end
        end
        STREAM: begin
          if (I_TREADY) begin
            if (tlast_r) begin
              state_r    <= DONE;
              tvalid_r   <= 1'b0;
              done_r     <= 1'b1;
              row_r      <= {RW{1'b0}};
              beat_r     <= {BW{1'b0}};
              row_last_r <= 1'b0;
              tlast_r    <= 1'b0;
            end else if (row_last_r) begin
              row_r      <= row_r + RW'(1);
              beat_r     <= {BW{1'b0}};
              row_last_r <= 1'b0;
              tlast_r    <= 1'b0;
            end else begin
              beat_r     <= beat_r + BW'(1);
              row_last_r <= (beat_r == BEAT_PENULT);
              tlast_r    <= (beat_r == BEAT_PENULT) && (row_r == ROW_FINAL);
            end
          end
        end
        DONE: begin
          state_r  <= IDLE;
          done_r   <= 1'b0;
          in_rdy_r <= 1'b1;
        end
        default: begin
          state_r    <= IDLE;
          in_rdy_r   <= 1'b1;
          tvalid_r   <= 1'b0;
          row_last_r <= 1'b0;
          tlast_r    <= 1'b0;
          done_r     <= 1'b0;
        end
      endcase
    end
  end

  att_beat_mux u_beat_mux (
    .mat  (buf_r),
    .row  (row_r),
    .beat (beat_r),
    .data (beat_data_s)
  );

  assign O_IN_RDY   = in_rdy_r;
  assign O_TVALID   = tvalid_r;
  assign O_TDATA    = tvalid_r ? beat_data_s : {(BEAT*D_W){1'b0}};
  assign O_TROW     = row_r;
  assign O_ROW_LAST = row_last_r;
  assign O_TLAST    = tlast_r;
  assign O_DONE     = done_r;
  assign O_OVF      = ovf_r;

endmodule

// File: tb/tb_att_out_streamer.sv
// Self-checking bench: directed scenarios with random data and stalls against a beat-queue model.
module tb_att_out_streamer;
  import att_pkg::*;

  typedef struct {
    logic [BEAT*D_W-1:0] data;
    logic [RW-1:0]       row;
    logic                rl;
    logic                tl;
  } beat_t;

  logic                             I_CLK = 1'b0;
  logic                             I_SYNC_RST = 1'b0;
  logic                             I_DATA_VLD = 1'b0;
  logic [0:DIM-1][0:D_K-1][D_W-1:0] I_ATT_DATA = '0;
  logic                             O_IN_RDY;
  logic                             O_TVALID;
  logic                             I_TREADY = 1'b0;
  logic [BEAT*D_W-1:0]              O_TDATA;
  logic [RW-1:0]                    O_TROW;
  logic                             O_ROW_LAST;
  logic                             O_TLAST;
  logic                             O_DONE;
  logic                             O_OVF;

  int total = 0;
  int bad = 0;

  logic [D_W-1:0] mat [DIM][D_K];
  beat_t          q[$];
  bit             done_ph = 1'b0;
  bit             ovf_m = 1'b0;

  att_out_streamer dut (
    .I_CLK      (I_CLK),
    .I_SYNC_RST (I_SYNC_RST),
    .I_DATA_VLD (I_DATA_VLD),
    .I_ATT_DATA (I_ATT_DATA),
    .O_IN_RDY   (O_IN_RDY),
    .O_TVALID   (O_TVALID),
    .I_TREADY   (I_TREADY),
    .O_TDATA    (O_TDATA),
    .O_TROW     (O_TROW),
    .O_ROW_LAST (O_ROW_LAST),
    .O_TLAST    (O_TLAST),
    .O_DONE     (O_DONE),
    .O_OVF      (O_OVF)
  );

  always #5 I_CLK = ~I_CLK;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fill_pattern();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < D_K; c++)
        mat[r][c] = D_W'((r * 8 + c) % 256);
  endtask

  task automatic fill_random();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < D_K; c++)
        mat[r][c] = D_W'($urandom);
  endtask

  // Drive the matrix bus from the bench's copy of the matrix.
  task automatic drive_mat();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < D_K; c++)
        I_ATT_DATA[r][c] = mat[r][c];
  endtask

  // Expected stream: every beat in row-major order, cut from the accepted matrix.
  task automatic load_model();
    beat_t b;
    q.delete();
    for (int k = 0; k < DIM * BPR; k++) begin
      b.row = RW'(k / BPR);
      b.rl  = ((k % BPR) == BPR - 1);
      b.tl  = (k == DIM * BPR - 1);
      for (int j = 0; j < BEAT; j++)
        b.data[j*D_W +: D_W] = mat[k / BPR][(k % BPR) * BEAT + j];
      q.push_back(b);
    end
  endtask

  // One clock: apply inputs, advance the model at the edge, compare #1 later.
  task automatic step(input logic vld, input logic rdy);
    bit pre_rdy;
    I_DATA_VLD = vld;
    I_TREADY   = rdy;
    @(posedge I_CLK);
    if (I_SYNC_RST) begin
      q.delete();
      done_ph = 1'b0;
      ovf_m   = 1'b0;
    end else begin
      pre_rdy = (q.size() == 0) && !done_ph;
      done_ph = 1'b0;
      if (q.size() > 0 && rdy) begin
        void'(q.pop_front());
        if (q.size() == 0) done_ph = 1'b1;
      end
      if (vld && pre_rdy) load_model();
      else if (vld) ovf_m = 1'b1;
    end
    #1;
    check("tvalid", 128'(O_TVALID), 128'(q.size() > 0));
    check("in_rdy", 128'(O_IN_RDY), 128'((q.size() == 0) && !done_ph));
    check("done", 128'(O_DONE), 128'(done_ph));
    check("ovf", 128'(O_OVF), 128'(ovf_m));
    if (q.size() > 0) begin
      check("tdata", 128'(O_TDATA), 128'(q[0].data));
      check("trow", 128'(O_TROW), 128'(q[0].row));
      check("row_last", 128'(O_ROW_LAST), 128'(q[0].rl));
      check("tlast", 128'(O_TLAST), 128'(q[0].tl));
    end
    I_DATA_VLD = 1'b0;
  endtask

  task automatic do_reset();
    I_SYNC_RST = 1'b1;
    step(1'b0, 1'b0);
    I_SYNC_RST = 1'b0;
  endtask

  task automatic run_until_idle(input bit rand_rdy, input int bound);
    int n = 0;
    while ((q.size() > 0 || done_ph) && n < bound) begin
      step(1'b0, rand_rdy ? 1'($urandom % 2) : 1'b1);
      n++;
    end
    check("idle_bound", 128'(n < bound), 128'(1));
  endtask

  initial begin
    int cnt;
    do_reset();
    check("rst_tdata", 128'(O_TDATA), 128'(0));
    check("rst_trow", 128'(O_TROW), 128'(0));
    check("rst_row_last", 128'(O_ROW_LAST), 128'(0));
    check("rst_tlast", 128'(O_TLAST), 128'(0));

    // Pattern matrix, consumer always ready.
    fill_pattern();
    drive_mat();
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check("beat0_const", 128'(O_TDATA), 128'h0f0e0d0c0b0a09080706050403020100);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1);
    check("beat8_const", 128'(O_TDATA), 128'h17161514131211100f0e0d0c0b0a0908);
    run_until_idle(1'b0, 200);

    // Same matrix with random back-pressure.
    step(1'b1, 1'b1);
    run_until_idle(1'b1, 2000);

    // Second pulse mid-stream must be dropped and flagged.
    fill_random();
    drive_mat();
    step(1'b1, 1'b1);
    for (int k = 0; k < 40; k++) step(1'b0, 1'b1);
    fill_random();
    drive_mat();
    step(1'b1, 1'b1);
    check("ovf_set", 128'(O_OVF), 128'(1));
    run_until_idle(1'b0, 200);
    check("ovf_sticky", 128'(O_OVF), 128'(1));
    step(1'b1, 1'b1);
    run_until_idle(1'b1, 2000);

    // Reset in the middle of a stream.
    fill_random();
    drive_mat();
    step(1'b1, 1'b1);
    for (int k = 0; k < 60; k++) step(1'b0, 1'b1);
    do_reset();
    check("midrst_tvalid", 128'(O_TVALID), 128'(0));
    check("midrst_in_rdy", 128'(O_IN_RDY), 128'(1));
    check("midrst_ovf", 128'(O_OVF), 128'(0));
    fill_random();
    drive_mat();
    step(1'b1, 1'b1);
    check("fresh_row0", 128'(O_TROW), 128'(0));
    run_until_idle(1'b0, 200);

    // Consumer stalls for 20 cycles right after capture.
    fill_random();
    drive_mat();
    step(1'b1, 1'b0);
    for (int k = 0; k < 19; k++) step(1'b0, 1'b0);
    cnt = 0;
    while (!O_DONE && cnt < 300) begin
      step(1'b0, 1'b1);
      cnt++;
    end
    check("accept_cycles", 128'(cnt), 128'(128));
    run_until_idle(1'b0, 10);

    // Pulse in the DONE cycle is lost; the next one is taken.
    do_reset();
    fill_random();
    drive_mat();
    step(1'b1, 1'b1);
    while (q.size() > 0) step(1'b0, 1'b1);
    fill_random();
    drive_mat();
    step(1'b1, 1'b1);
    check("b2b_ovf", 128'(O_OVF), 128'(1));
    check("b2b_tvalid", 128'(O_TVALID), 128'(0));
    step(1'b1, 1'b1);
    check("b2b_capture", 128'(O_TVALID), 128'(1));
    run_until_idle(1'b1, 2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
